seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_display_pkg.sv | 18 +
 rtl/seg7_decode.sv | 26 ++
 rtl/seg_display_mux.sv | 120 ++++++++++++
 tb/tb_seg_display_mux.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package seg_display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [1:0] IDX_THOUSANDTHS = 2'd0;
  localparam logic [1:0] IDX_HUNDRETHS   = 2'd1;
  localparam logic [1:0] IDX_TENTHS      = 2'd2;
  localparam logic [1:0] IDX_ONES        = 2'd3;

  // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decode; non-BCD codes show a dash.
module seg7_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Scans a frozen snapshot of four BCD digits onto a common-anode display,
// with a blanking gap between digits to avoid ghosting.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ones,
  input  logic [3:0] tenths,
  input  logic [3:0] hundreths,
  input  logic [3:0] thousandths,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PRESC_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned SNAP_W  = 15;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [3:0]           dec_in;
  logic [6:0]           dec_seg;

  seg7_decode u_decode (
    .bcd_i (dec_in),
    .seg_o (dec_seg)
  );

  // Next state, snapshot capture, and outputs derived from the next state so
  // the registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    blank_d = blank_q;
    snap_d  = snap_q;
    dec_in  = 4'd0;
    an_d    = 4'b1111;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;

    case (state_q)
      ST_BLANK: begin
        if ((idx_q == IDX_THOUSANDTHS) && (blank_q == BLANK_W'(0)) && !hold) begin
          snap_d = {ones, tenths, hundreths, thousandths};
        end
        if (blank_q == BLANK_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          blank_d = BLANK_W'(0);
          presc_d = PRESC_W'(0);
        end else begin
          blank_d = blank_q + BLANK_W'(1);
        end
      end
      ST_DRIVE: begin
        if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
          state_d = ST_BLANK;
          idx_d   = idx_q + 2'd1;
          presc_d = PRESC_W'(0);
          blank_d = BLANK_W'(0);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase

    case (idx_d)
      IDX_THOUSANDTHS: dec_in = snap_d[3:0];
      IDX_HUNDRETHS:   dec_in = snap_d[7:4];
      IDX_TENTHS:      dec_in = snap_d[11:8];
      default:         dec_in = {1'b0, snap_d[14:12]};
    endcase

    if (state_d == ST_DRIVE) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = dec_seg;
      dp_d  = (idx_d != IDX_ONES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= IDX_THOUSANDTHS;
      presc_q <= '0;
      blank_q <= '0;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench: a cycle-position reference model of the scan schedule.
module tb_seg_display_mux;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic [2:0] ones = 3'd0;
  logic [3:0] tenths = 4'd0, hundreths = 4'd0, thousandths = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int          tests = 0;
  int          fails = 0;
  int          t = 0;
  logic [14:0] m_snap = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always #5 clk = ~clk;

  seg_display_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .ones(ones), .tenths(tenths), .hundreths(hundreths),
    .thousandths(thousandths), .hold(hold), .an(an), .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs from the cycle's position within the frame.
  task automatic model_expect();
    int ph, slot, s;
    logic [3:0] dig;
    ph = t % FRAME; slot = ph / SLOT; s = ph % SLOT;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    if (s >= BC) begin
      e_an[slot] = 1'b0;
      case (slot)
        0: dig = m_snap[3:0];
        1: dig = m_snap[7:4];
        2: dig = m_snap[11:8];
        default: dig = {1'b0, m_snap[14:12]};
      endcase
      e_seg = pat(dig);
      e_dp  = (slot != 3);
    end
  endtask

  // Move the model and the DUT one cycle forward.
  task automatic advance();
    if ((t % FRAME) == 0 && !hold) m_snap = {ones, tenths, hundreths, thousandths};
    @(posedge clk); #1;
    t++;
  endtask

  task automatic set_digits(input logic [2:0] o, input logic [3:0] te, hu, th);
    ones = o; tenths = te; hundreths = hu; thousandths = th;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_digits(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", an); end
      tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got %b want 1111111", seg); end
      tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", dp); end
    end
    @(posedge clk); #1;
    rst = 1'b0; t = 0; m_snap = '0;
  endtask

  task automatic test_sequence();
    set_digits(3'd3, 4'd4, 4'd5, 4'd6); hold = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk); model_expect();
      tests++; if (an !== e_an) begin fails++; $display("FAIL seq_an t=%0d got %b want %b", t, an, e_an); end
      tests++; if (seg !== e_seg) begin fails++; $display("FAIL seq_seg t=%0d got %b want %b", t, seg, e_seg); end
      tests++; if (dp !== e_dp) begin fails++; $display("FAIL seq_dp t=%0d got %b want %b", t, dp, e_dp); end
      if (t == 1) begin
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL seq_first_blank got %b want 1111", an); end
      end
      if (t == 2) begin
        tests++; if ({an, seg} !== {4'b1110, 7'b0000010}) begin fails++; $display("FAIL seq_digit0 got %b/%b want 1110/0000010", an, seg); end
      end
      if (t == 8) begin
        tests++; if ({an, seg} !== {4'b1101, 7'b0010010}) begin fails++; $display("FAIL seq_digit1 got %b/%b want 1101/0010010", an, seg); end
      end
      advance();
    end
  endtask

  task automatic test_dp_ones();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk); model_expect();
      tests++; if (dp !== e_dp) begin fails++; $display("FAIL dp t=%0d got %b want %b", t, dp, e_dp); end
      if ((t % FRAME) == 3 * SLOT + BC) begin
        tests++; if ({an, seg, dp} !== {4'b0111, 7'b0110000, 1'b0}) begin fails++; $display("FAIL dp_ones got %b/%b/%b want 0111/0110000/0", an, seg, dp); end
      end
      advance();
    end
  endtask

  task automatic test_midframe_change();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t % FRAME) == BC + 1 && i < FRAME) thousandths = 4'd9;
      @(negedge clk); model_expect();
      tests++; if (seg !== e_seg) begin fails++; $display("FAIL mid_seg t=%0d got %b want %b", t, seg, e_seg); end
      tests++; if (an !== e_an) begin fails++; $display("FAIL mid_an t=%0d got %b want %b", t, an, e_an); end
      if (i == BC + 2) begin
        tests++; if (seg !== 7'b0000010) begin fails++; $display("FAIL mid_keep got %b want 0000010", seg); end
      end
      if (i == FRAME + BC) begin
        tests++; if (seg !== 7'b0010000) begin fails++; $display("FAIL mid_new got %b want 0010000", seg); end
      end
      advance();
    end
  endtask

  task automatic test_hold();
    set_digits(3'd3, 4'd4, 4'd5, 4'd6);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == FRAME - 1) begin set_digits(3'd0, 4'd0, 4'd0, 4'd0); hold = 1'b1; end
      if (i == FRAME + 1) hold = 1'b0;
      @(negedge clk); model_expect();
      tests++; if (seg !== e_seg) begin fails++; $display("FAIL hold_seg t=%0d got %b want %b", t, seg, e_seg); end
      tests++; if (an !== e_an) begin fails++; $display("FAIL hold_an t=%0d got %b want %b", t, an, e_an); end
      if (i == FRAME + BC) begin
        tests++; if (seg !== 7'b0000010) begin fails++; $display("FAIL hold_frozen got %b want 0000010", seg); end
      end
      if (i == 2 * FRAME + BC) begin
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL hold_released got %b want 1000000", seg); end
      end
      advance();
    end
  endtask

  task automatic test_dash();
    set_digits(3'd3, 4'd4, 4'd5, 4'hB);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk); model_expect();
      tests++; if (seg !== e_seg) begin fails++; $display("FAIL dash_seg t=%0d got %b want %b", t, seg, e_seg); end
      if (i == FRAME + BC) begin
        tests++; if (seg !== 7'b0111111) begin fails++; $display("FAIL dash_digit0 got %b want 0111111", seg); end
      end
      if (i == FRAME + SLOT + BC) begin
        tests++; if (seg !== 7'b0010010) begin fails++; $display("FAIL dash_digit1 got %b want 0010010", seg); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_drive();
    set_digits(3'd3, 4'd4, 4'd5, 4'd6);
    while ((t % FRAME) != 2 * SLOT + BC) advance();
    rst = 1'b1;
    @(negedge clk); model_expect();
    tests++; if (an !== 4'b1011) begin fails++; $display("FAIL rst_pre_an got %b want 1011", an); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin fails++; $display("FAIL rst_mid got %b/%b/%b want 1111/1111111/1", an, seg, dp); end
    @(posedge clk); #1;
    rst = 1'b0; t = 0; m_snap = '0;
    test_sequence();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) set_digits(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      hold = ($urandom_range(0, 3) == 0);
      @(negedge clk); model_expect();
      tests++; if (an !== e_an) begin fails++; $display("FAIL rand_an t=%0d got %b want %b", t, an, e_an); end
      tests++; if (seg !== e_seg) begin fails++; $display("FAIL rand_seg t=%0d got %b want %b", t, seg, e_seg); end
      tests++; if (dp !== e_dp) begin fails++; $display("FAIL rand_dp t=%0d got %b want %b", t, dp, e_dp); end
      advance();
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_dp_ones();
    test_midframe_change();
    test_hold();
    test_dash();
    test_reset_mid_drive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
